// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline register.
// Holds the constant-function used to size the occupancy counter.
package pipe_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One stage of the elastic pipeline: a valid flag plus a payload register.
// Payload only changes when a valid beat is loaded, so bubbles never overwrite data.
module pipe_stage #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Reset beats flush; flush beats a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= vin;
    end
  end

  // Flush leaves the payload untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= RESET_VALUE;
    end else if (!flush && load && vin) begin
      r_data <= din;
    end
  end

  assign vout = r_valid;
  assign dout = r_data;

endmodule

// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH stages with bubble collapsing, flush and occupancy count.
// The ready chain and popcount live here; storage lives in pipe_stage.
module pipe_reg_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = clog2(DEPTH + 1);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a raised valid holds its data until the transfer.
  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_v;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_in_fire;
  logic [CNT_W-1:0] w_count;

  // A stage can load when it is empty or the stage ahead of it is moving.
  assign w_rdy[DEPTH] = out_ready;
  for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
    assign w_rdy[i] = !w_v[i] | w_rdy[i+1];
  end

  assign in_ready  = w_rdy[0] & !flush & !reset;
  assign w_in_fire = in_valid & in_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (w_rdy[i]),
        .vin   (w_in_fire),
        .din   (in_data),
        .vout  (w_v[i]),
        .dout  (w_d[i])
      );
    end else begin : g_rest
      pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
      ) u_stage (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .load  (w_rdy[i]),
        .vin   (w_v[i-1]),
        .din   (w_d[i-1]),
        .vout  (w_v[i]),
        .dout  (w_d[i])
      );
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CNT_W'(w_v[i]);
    end
  end

  assign out_valid = w_v[DEPTH-1];
  assign out_data  = w_d[DEPTH-1];
  assign count     = w_count;

  // A stalled output beat must hold its payload.
  property p_out_hold;
    @(posedge clk) disable iff (reset)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data));
  endproperty
  a_out_hold: assert property (p_out_hold);

  a_count_range: assert property (@(posedge clk) disable iff (reset) w_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: directed scenarios on a DEPTH=2 instance, then randomized
// traffic on DEPTH=1/2/4 instances against a queue-based reference model.
module tb_pipe_reg_elastic;

  logic clk = 1'b0;
  logic reset;

  logic [2:0]       flush_v;
  logic [2:0]       in_valid_v;
  logic [2:0]       in_ready_v;
  logic [2:0]       out_valid_v;
  logic [2:0]       out_ready_v;
  logic [2:0][31:0] in_data_v;
  logic [2:0][31:0] out_data_v;
  logic [0:0]       count1;
  logic [1:0]       count2;
  logic [2:0]       count4;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned cyc = 0;

  logic [31:0] exp_q[$];
  int unsigned stamp_q[$];
  int          accepted;
  logic        p_ov, p_or, p_fl;
  logic [31:0] p_d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(1), .RESET_VALUE(32'h0)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush_v[0]),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_data(in_data_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]),
    .count(count1)
  );

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(2), .RESET_VALUE(32'hDEAD)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush_v[1]),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_data(in_data_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]),
    .count(count2)
  );

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(4), .RESET_VALUE(32'h0)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush_v[2]),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_data(in_data_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .out_data(out_data_v[2]),
    .count(count4)
  );

  function automatic logic [31:0] count_of(input int idx);
    case (idx)
      0:       return {31'b0, count1};
      1:       return {30'b0, count2};
      default: return {29'b0, count4};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle on the DEPTH=2 instance and stop at the sample point.
  task automatic cyc_in(input logic iv, input logic [31:0] d, input logic ordy,
                        input logic fl, input logic rst);
    @(posedge clk);
    #1;
    in_valid_v[1]  = iv;
    in_data_v[1]   = d;
    out_ready_v[1] = ordy;
    flush_v[1]     = fl;
    reset          = rst;
    @(negedge clk);
  endtask

  // Reference model: the pipe is an ordered queue of accepted beats; the oldest beat
  // reaches the output exactly depth cycles after acceptance, since nothing blocks it.
  task automatic model_cycle(input int idx, input int depth);
    int   n;
    logic exp_ov;
    n = exp_q.size();
    check($sformatf("count_d%0d", depth), count_of(idx), n);
    check($sformatf("in_ready_d%0d", depth), in_ready_v[idx],
          !flush_v[idx] && (n < depth || out_ready_v[idx]));
    exp_ov = (n > 0) && (int'(cyc - stamp_q[0]) >= depth);
    check($sformatf("out_valid_d%0d", depth), out_valid_v[idx], exp_ov);
    if (p_ov && !p_or && !p_fl)
      check($sformatf("hold_data_d%0d", depth), out_data_v[idx], p_d);
    if (out_valid_v[idx] && out_ready_v[idx]) begin
      check($sformatf("out_nonempty_d%0d", depth), n > 0, 1'b1);
      if (n > 0) begin
        check($sformatf("out_data_d%0d", depth), out_data_v[idx], exp_q[0]);
        void'(exp_q.pop_front());
        void'(stamp_q.pop_front());
      end
    end
    if (in_valid_v[idx] && in_ready_v[idx]) begin
      exp_q.push_back(in_data_v[idx]);
      stamp_q.push_back(cyc);
      accepted++;
    end
    if (flush_v[idx]) begin
      exp_q.delete();
      stamp_q.delete();
    end
    p_ov = out_valid_v[idx];
    p_or = out_ready_v[idx];
    p_fl = flush_v[idx];
    p_d  = out_data_v[idx];
  endtask

  task automatic run_random(input int idx, input int depth, input int beats);
    int cycles;
    exp_q.delete();
    stamp_q.delete();
    accepted = 0;
    cycles   = 0;
    p_ov = 1'b0; p_or = 1'b0; p_fl = 1'b0; p_d = '0;
    while (accepted < beats && cycles < 20000) begin
      @(posedge clk);
      #1;
      in_valid_v[idx]  = ($urandom_range(0, 99) < 70);
      in_data_v[idx]   = $urandom;
      out_ready_v[idx] = ($urandom_range(0, 99) < 65);
      flush_v[idx]     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      model_cycle(idx, depth);
      cycles++;
    end
    check($sformatf("budget_d%0d", depth), accepted >= beats, 1'b1);
    for (int k = 0; k < depth + 2; k++) begin
      @(posedge clk);
      #1;
      in_valid_v[idx]  = 1'b0;
      out_ready_v[idx] = 1'b1;
      flush_v[idx]     = 1'b0;
      @(negedge clk);
      model_cycle(idx, depth);
    end
    check($sformatf("drain_q_d%0d", depth), exp_q.size(), 0);
    check($sformatf("drain_cnt_d%0d", depth), count_of(idx), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    flush_v     = '0;
    in_valid_v  = '0;
    in_data_v   = '0;
    out_ready_v = 3'b111;

    // Reset: in_ready low while reset is high, then reset values.
    @(negedge clk);
    check("rst_in_ready", in_ready_v[1], 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid_v[1], 1'b0);
    check("rst_count", count_of(1), 0);
    check("rst_out_data", out_data_v[1], 32'hDEAD);
    check("rst_out_data_d4", out_data_v[2], 32'h0);
    check("rst_in_ready_after", in_ready_v[1], 1'b1);

    // Streaming with out_ready held high.
    cyc_in(1, 32'h11, 1, 0, 0); check("strm_ov0", out_valid_v[1], 1'b0);
    check("strm_ir0", in_ready_v[1], 1'b1);
    cyc_in(1, 32'h22, 1, 0, 0); check("strm_ov1", out_valid_v[1], 1'b0);
    cyc_in(1, 32'h33, 1, 0, 0); check("strm_ov2", out_valid_v[1], 1'b1);
    check("strm_d11", out_data_v[1], 32'h11);
    cyc_in(0, 32'h0, 1, 0, 0);  check("strm_d22", out_data_v[1], 32'h22);
    check("strm_ov3", out_valid_v[1], 1'b1);
    cyc_in(0, 32'h0, 1, 0, 0);  check("strm_d33", out_data_v[1], 32'h33);
    cyc_in(0, 32'h0, 1, 0, 0);  check("strm_empty", out_valid_v[1], 1'b0);

    // Backpressure.
    cyc_in(1, 32'hA, 0, 0, 0);  check("bp_ir_a", in_ready_v[1], 1'b1);
    cyc_in(1, 32'hB, 0, 0, 0);  check("bp_ir_b", in_ready_v[1], 1'b1);
    cyc_in(1, 32'hC, 0, 0, 0);  check("bp_ir_c_blocked", in_ready_v[1], 1'b0);
    check("bp_cnt_full", count_of(1), 2);
    check("bp_d_a_held", out_data_v[1], 32'hA);
    cyc_in(1, 32'hC, 1, 0, 0);  check("bp_ir_c_same_cycle", in_ready_v[1], 1'b1);
    check("bp_out_a", out_data_v[1], 32'hA);
    check("bp_ov_a", out_valid_v[1], 1'b1);
    cyc_in(0, 32'h0, 1, 0, 0);  check("bp_out_b", out_data_v[1], 32'hB);
    check("bp_cnt_b", count_of(1), 2);
    cyc_in(0, 32'h0, 1, 0, 0);  check("bp_out_c", out_data_v[1], 32'hC);
    check("bp_cnt_c", count_of(1), 1);
    cyc_in(0, 32'h0, 1, 0, 0);  check("bp_cnt_empty", count_of(1), 0);

    // Bubble collapse toward the stalled output.
    cyc_in(1, 32'h5, 0, 0, 0);
    cyc_in(0, 32'h0, 0, 0, 0);  check("bub_cnt1", count_of(1), 1);
    check("bub_ov_early", out_valid_v[1], 1'b0);
    cyc_in(1, 32'h6, 0, 0, 0);  check("bub_cnt1_out", count_of(1), 1);
    check("bub_ov", out_valid_v[1], 1'b1);
    check("bub_d5", out_data_v[1], 32'h5);
    check("bub_ir", in_ready_v[1], 1'b1);
    cyc_in(0, 32'h0, 0, 0, 0);  check("bub_cnt2", count_of(1), 2);
    check("bub_d5_hold", out_data_v[1], 32'h5);

    // Flush with a full pipe and a pending input beat.
    cyc_in(1, 32'h77, 1, 1, 0); check("fl_ir", in_ready_v[1], 1'b0);
    check("fl_ov", out_valid_v[1], 1'b1);
    check("fl_deliver", out_data_v[1], 32'h5);
    cyc_in(0, 32'h0, 1, 0, 0);  check("fl_cnt", count_of(1), 0);
    check("fl_ov_after", out_valid_v[1], 1'b0);
    check("fl_data_kept", out_data_v[1], 32'h5);
    for (int k = 0; k < 3; k++) begin
      cyc_in(0, 32'h0, 1, 0, 0);
      check("fl_no_77", out_valid_v[1], 1'b0);
    end

    // Reset mid-operation overrides flush and the new input.
    cyc_in(1, 32'h81, 0, 0, 0);
    cyc_in(1, 32'h82, 0, 0, 0);
    cyc_in(0, 32'h0, 0, 0, 0);  check("mr_cnt_full", count_of(1), 2);
    cyc_in(1, 32'h99, 1, 1, 1); check("mr_ir", in_ready_v[1], 1'b0);
    cyc_in(0, 32'h0, 1, 0, 0);  check("mr_ov", out_valid_v[1], 1'b0);
    check("mr_cnt", count_of(1), 0);
    check("mr_data", out_data_v[1], 32'hDEAD);

    // Randomized regression.
    run_random(0, 1, 1000);
    run_random(2, 4, 1000);
    run_random(1, 2, 500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
